// File: rtl/img_process_cfg.sv
`default_nettype none
// ============================================================================
// Module   : img_process_cfg
// Brief    : RGB565 stream processor (bypass / gray / binary / inverted binary)
//            with per-frame config capture, frame counting and error flags.
// Revision : 1.0  initial release
// ============================================================================
module img_process_cfg #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic [1:0]  mode_cfg,
    input  logic [7:0]  thresh_cfg,
    input  logic        err_clr,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [15:0] frame_cnt,
    output logic        sop_err,
    output logic        len_err,
    output logic        orphan_err
);

    localparam logic [0:0]       c_IDLE      = 1'b0;
    localparam logic [0:0]       c_ACTIVE    = 1'b1;
    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [15:0]      r_frame_cnt;
    logic [1:0]       r_mode_act;
    logic [7:0]       r_thr_act;
    logic             r_sop_err;
    logic             r_len_err;
    logic             r_orphan_err;

    logic             w_accept;
    logic             w_frame_end;
    logic [CNT_W-1:0] w_len_val;
    logic             w_sop_set;
    logic             w_len_set;
    logic             w_orphan_set;
    logic [1:0]       w_pix_mode;
    logic [7:0]       w_pix_thr;

    // A sop pixel always runs with the freshly captured config, not the stale one.
    assign w_accept     = din_vld & (din_sop | (r_state == c_ACTIVE));
    assign w_frame_end  = w_accept & din_eop;
    assign w_len_val    = din_sop ? c_one : (r_pix_cnt + c_one);
    assign w_sop_set    = din_vld & din_sop & (r_state == c_ACTIVE);
    assign w_len_set    = w_frame_end & (w_len_val != c_frame_len);
    assign w_orphan_set = din_vld & ~din_sop & (r_state == c_IDLE);
    assign w_pix_mode   = din_sop ? mode_cfg   : r_mode_act;
    assign w_pix_thr    = din_sop ? thresh_cfg : r_thr_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_pix_cnt   <= '0;
            r_frame_cnt <= '0;
            r_mode_act  <= 2'd0;
            r_thr_act   <= 8'h80;
        end else if (din_vld) begin
            if (din_sop) begin
                r_mode_act <= mode_cfg;
                r_thr_act  <= thresh_cfg;
            end
            if (w_accept) begin
                if (din_eop) begin
                    r_state     <= c_IDLE;
                    r_pix_cnt   <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_state   <= c_ACTIVE;
                    r_pix_cnt <= w_len_val;
                end
            end
        end
    end

    // Sticky flags: a new error in the clearing cycle must survive the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sop_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_orphan_err <= 1'b0;
        end else begin
            r_sop_err    <= w_sop_set    | (r_sop_err    & ~err_clr);
            r_len_err    <= w_len_set    | (r_len_err    & ~err_clr);
            r_orphan_err <= w_orphan_set | (r_orphan_err & ~err_clr);
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign sop_err    = r_sop_err;
    assign len_err    = r_len_err;
    assign orphan_err = r_orphan_err;

    // ---------------- stage 1: capture accepted pixel and its config ----------
    logic        r_s1_vld, r_s1_sop, r_s1_eop;
    logic [15:0] r_s1_din;
    logic [1:0]  r_s1_mode;
    logic [7:0]  r_s1_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_sop  <= 1'b0;
            r_s1_eop  <= 1'b0;
            r_s1_din  <= 16'd0;
            r_s1_mode <= 2'd0;
            r_s1_thr  <= 8'd0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_sop  <= din_sop;
                r_s1_eop  <= din_eop;
                r_s1_din  <= din;
                r_s1_mode <= w_pix_mode;
                r_s1_thr  <= w_pix_thr;
            end
        end
    end

    // ---------------- stage 2: luma weighting ---------------------------------
    logic [7:0]  w_r8, w_g8, w_b8;
    logic [15:0] w_sum;

    assign w_r8  = {r_s1_din[15:11], r_s1_din[15:13]};
    assign w_g8  = {r_s1_din[10:5],  r_s1_din[10:9]};
    assign w_b8  = {r_s1_din[4:0],   r_s1_din[4:2]};
    // Weights sum to 256, so the total peaks at 65280 and fits 16 bits.
    assign w_sum = 16'd77  * {8'd0, w_r8}
                 + 16'd150 * {8'd0, w_g8}
                 + 16'd29  * {8'd0, w_b8};

    logic        r_s2_vld, r_s2_sop, r_s2_eop;
    logic [15:0] r_s2_din;
    logic [1:0]  r_s2_mode;
    logic [7:0]  r_s2_thr;
    logic [7:0]  r_s2_gray;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_sop  <= 1'b0;
            r_s2_eop  <= 1'b0;
            r_s2_din  <= 16'd0;
            r_s2_mode <= 2'd0;
            r_s2_thr  <= 8'd0;
            r_s2_gray <= 8'd0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sop  <= r_s1_sop;
                r_s2_eop  <= r_s1_eop;
                r_s2_din  <= r_s1_din;
                r_s2_mode <= r_s1_mode;
                r_s2_thr  <= r_s1_thr;
                r_s2_gray <= 8'(w_sum >> 8);
            end
        end
    end

    // ---------------- stage 3: output formatting ------------------------------
    logic        w_bin;
    logic [15:0] w_pix_out;

    assign w_bin = (r_s2_gray >= r_s2_thr);

    always_comb begin
        w_pix_out = r_s2_din;
        case (r_s2_mode)
            2'd0:    w_pix_out = r_s2_din;
            2'd1:    w_pix_out = {r_s2_gray[7:3], r_s2_gray[7:2], r_s2_gray[7:3]};
            2'd2:    w_pix_out = {16{w_bin}};
            default: w_pix_out = {16{~w_bin}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= 16'd0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout_vld <= r_s2_vld;
            dout_sop <= r_s2_vld & r_s2_sop;
            dout_eop <= r_s2_vld & r_s2_eop;
            if (r_s2_vld) begin
                dout <= w_pix_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_process_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_process_cfg
// Brief    : Directed self-checking bench for img_process_cfg (4x2 frames).
// Revision : 1.0  initial release
// ============================================================================
module tb_img_process_cfg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'd0;
    logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [1:0]  mode_cfg = 2'd0;
    logic [7:0]  thresh_cfg = 8'd0;
    logic        err_clr = 1'b0;
    logic [15:0] dout;
    logic        dout_vld, dout_sop, dout_eop;
    logic [15:0] frame_cnt;
    logic        sop_err, len_err, orphan_err;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Expected-output delay line: index 2 is what the DUT shows now.
    logic        pv_v[3];
    logic        pv_s[3];
    logic        pv_e[3];
    logic [15:0] pv_d[3];
    logic [15:0] exp_last;

    logic [15:0] vals[8];
    logic [15:0] bin2[8];

    img_process_cfg #(.IMG_W(4), .IMG_H(2), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .mode_cfg(mode_cfg), .thresh_cfg(thresh_cfg),
        .err_clr(err_clr), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .frame_cnt(frame_cnt), .sop_err(sop_err),
        .len_err(len_err), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [15:0] d, input logic v, input logic s, input logic e,
                        input logic xv, input logic [15:0] xd, input logic r);
        din = d; din_vld = v; din_sop = s; din_eop = e; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                pv_v[i] = 1'b0; pv_s[i] = 1'b0; pv_e[i] = 1'b0; pv_d[i] = 16'd0;
            end
            exp_last = 16'd0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                pv_v[i] = pv_v[i-1]; pv_s[i] = pv_s[i-1];
                pv_e[i] = pv_e[i-1]; pv_d[i] = pv_d[i-1];
            end
            pv_v[0] = xv; pv_s[0] = s; pv_e[0] = e; pv_d[0] = xd;
            if (pv_v[2]) exp_last = pv_d[2];
        end
        chk("dout_vld", {15'd0, dout_vld}, {15'd0, pv_v[2]});
        chk("dout_sop", {15'd0, dout_sop}, {15'd0, pv_v[2] & pv_s[2]});
        chk("dout_eop", {15'd0, dout_eop}, {15'd0, pv_v[2] & pv_e[2]});
        chk("dout",     dout, exp_last);
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; rst = 1'b0;
    endtask

    task automatic pix(input logic [15:0] d, input logic s, input logic e, input logic [15:0] xd);
        tick(d, 1'b1, s, e, 1'b1, xd, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic chk_status(input logic xs, input logic xl, input logic xo, input logic [15:0] xf);
        chk("sop_err",    {15'd0, sop_err},    {15'd0, xs});
        chk("len_err",    {15'd0, len_err},    {15'd0, xl});
        chk("orphan_err", {15'd0, orphan_err}, {15'd0, xo});
        chk("frame_cnt",  frame_cnt, xf);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pv_v[i] = 1'b0; pv_s[i] = 1'b0; pv_e[i] = 1'b0; pv_d[i] = 16'd0;
        end
        exp_last = 16'd0;
        // gray: F800->76, 07E0->149, FFFF->255, 0000->0, 001F->28 ; thr 128
        vals = '{16'hF800, 16'h07E0, 16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        bin2 = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

        tick(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        tick(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        chk_status(1'b0, 1'b0, 1'b0, 16'd0);

        // Orphan pixel after reset is dropped; set beats a simultaneous clear
        tick(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        idle(3);
        chk_status(1'b0, 1'b0, 1'b1, 16'd0);
        err_clr = 1'b1;
        tick(16'h4321, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        chk_status(1'b0, 1'b0, 1'b1, 16'd0);
        idle(1);
        err_clr = 1'b0;
        chk_status(1'b0, 1'b0, 1'b0, 16'd0);

        // Gray, full-length white frame
        mode_cfg = 2'd1; thresh_cfg = 8'd128;
        for (int i = 0; i < 8; i++) pix(16'hFFFF, i == 0, i == 7, 16'hFFFF);
        idle(3);
        chk_status(1'b0, 1'b0, 1'b0, 16'd1);

        // Gray of primaries, with idle gaps inside the frame
        pix(16'hF800, 1'b1, 1'b0, 16'h4A69);
        pix(16'h07E0, 1'b0, 1'b0, 16'h94B2);
        idle(2);
        pix(16'h001F, 1'b0, 1'b0, 16'h18E3);
        pix(16'h0000, 1'b0, 1'b0, 16'h0000);
        idle(1);
        for (int i = 0; i < 4; i++) pix(16'hFFFF, 1'b0, i == 3, 16'hFFFF);
        idle(3);
        chk_status(1'b0, 1'b0, 1'b0, 16'd2);

        // Binary then inverted binary; mid-frame config change ignored
        mode_cfg = 2'd2; thresh_cfg = 8'd128;
        for (int i = 0; i < 8; i++) pix(vals[i], i == 0, i == 7, bin2[i]);
        mode_cfg = 2'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin mode_cfg = 2'd0; thresh_cfg = 8'd0; end
            pix(vals[i], i == 0, i == 7, ~bin2[i]);
        end
        idle(3);
        chk_status(1'b0, 1'b0, 1'b0, 16'd4);

        // Bypass frame with mode switched to binary mid-frame; next frame binary
        mode_cfg = 2'd0; thresh_cfg = 8'd128;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mode_cfg = 2'd2;
            pix(vals[i], i == 0, i == 7, vals[i]);
        end
        for (int i = 0; i < 8; i++) pix(vals[i], i == 0, i == 7, bin2[i]);
        idle(3);
        chk_status(1'b0, 1'b0, 1'b0, 16'd6);

        // Threshold boundary at equality, then a second sop restarts the frame
        thresh_cfg = 8'd76;
        pix(16'hF800, 1'b1, 1'b0, 16'hFFFF);
        pix(16'h07E0, 1'b0, 1'b0, 16'hFFFF);
        pix(16'h001F, 1'b0, 1'b0, 16'h0000);
        thresh_cfg = 8'd77;
        pix(16'hF800, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 9; i++) pix(16'hF800, 1'b0, i == 8, 16'h0000);
        idle(3);
        chk_status(1'b1, 1'b1, 1'b0, 16'd7);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk_status(1'b0, 1'b0, 1'b0, 16'd7);

        // Reset mid-frame flushes the pipeline and returns FSM to idle
        mode_cfg = 2'd0;
        pix(16'hAAAA, 1'b1, 1'b0, 16'hAAAA);
        pix(16'h5555, 1'b0, 1'b0, 16'h5555);
        tick(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        idle(4);
        chk_status(1'b0, 1'b0, 1'b0, 16'd0);
        tick(16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        idle(3);
        chk_status(1'b0, 1'b0, 1'b1, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/img_process_cfg.md
IMG_PROCESS_CFG -- requirements
Module: img_process_cfg

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line used for the frame-length check.
REQ-002 Parameter IMG_H, default 480, active lines per frame used for the frame-length check.
REQ-003 Parameter CNT_W, default 20, width of the per-frame pixel counter; SHALL satisfy 2^CNT_W > IMG_W*IMG_H.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port din  input  16  RGB565 pixel, R[15:11] G[10:5] B[4:0].
REQ-007 Port din_vld  input  1  din valid this cycle.
REQ-008 Port din_sop  input  1  first pixel of frame; qualified by din_vld.
REQ-009 Port din_eop  input  1  last pixel of frame; qualified by din_vld.
REQ-010 Port mode_cfg  input  2  0 bypass RGB, 1 gray, 2 binary, 3 inverted binary.
REQ-011 Port thresh_cfg  input  8  binarisation threshold.
REQ-012 Port err_clr  input  1  clears sticky error flags.
REQ-013 Port dout  output  16  processed pixel.
REQ-014 Port dout_vld / dout_sop / dout_eop  output  1 each  delayed input strobes of accepted pixels.
REQ-015 Port frame_cnt  output  16  completed frames, wraps 0xFFFF->0.
REQ-016 Port sop_err / len_err / orphan_err  output  1 each  sticky error flags.

Function
REQ-017 Gray SHALL be computed as R8=(R5<<3)|(R5>>2), G8=(G6<<2)|(G6>>4), B8=(B5<<3)|(B5>>2), gray=(77*R8+150*G8+29*B8)>>8, 16-bit unsigned sum, no overflow; white 0xFFFF -> gray 255, black -> 0.
REQ-018 Binary bit SHALL be 1 when gray >= thr_act, else 0; mode 3 SHALL output its complement.
REQ-019 dout SHALL be: mode 0 din unchanged; mode 1 {gray[7:3],gray[7:2],gray[7:3]}; modes 2/3 all 16 bits equal to the binary bit.
REQ-020 Latency SHALL be exactly 3 cycles from accepted din_vld to dout_vld in every mode; the pipeline is fully pipelined, one pixel per cycle, no backpressure.
REQ-021 dout_sop/dout_eop SHALL be asserted only together with dout_vld; dout SHALL hold its last value when dout_vld=0.
REQ-022 FSM states IDLE, ACTIVE; reset state IDLE.
REQ-023 IDLE: din_vld&din_sop SHALL latch mode_cfg->mode_act and thresh_cfg->thr_act, accept the pixel, set pix_cnt=1, go ACTIVE; if din_eop is also set, the frame ends that cycle (len check applied, stay IDLE).
REQ-024 IDLE: din_vld without din_sop SHALL drop the pixel (no output) and set orphan_err.
REQ-025 ACTIVE: din_vld without sop/eop SHALL accept the pixel and increment pix_cnt.
REQ-026 ACTIVE: din_vld&din_sop SHALL set sop_err, restart the frame as in REQ-023 (relatch config, pix_cnt=1), and SHALL NOT increment frame_cnt.
REQ-027 ACTIVE: din_vld&din_eop (no sop) SHALL accept the pixel, set len_err if pix_cnt+1 != IMG_W*IMG_H, increment frame_cnt, return to IDLE.
REQ-028 mode_cfg/thresh_cfg changes mid-frame SHALL have no effect until the next accepted sop; pixels already in the pipeline use the config captured for their frame.
REQ-029 err_clr SHALL clear all three flags; if an error condition occurs in the same cycle, the set SHALL win.
REQ-030 Cycles with din_vld=0 SHALL not change FSM, counters, or flags (except err_clr).

Reset
REQ-031 rst SHALL force: FSM IDLE, pix_cnt 0, frame_cnt 0, all error flags 0, dout 0, dout_vld/sop/eop 0, mode_act 0, thr_act 0x80, and flush the pipeline valid bits.
REQ-032 rst asserted mid-frame SHALL discard all in-flight pixels; no dout_vld SHALL appear from pre-reset input.

Verification
REQ-033 Mode 1, frame of IMG_W*IMG_H pixels of 0xFFFF -> each dout=0xFFFF 3 cycles after input, dout_sop on first, dout_eop on last, frame_cnt=1, no errors.
REQ-034 Mode 2, thresh 128, pixels 0xF800 (gray 76) then 0x07E0 (gray 149) -> dout 0x0000 then 0xFFFF; mode 3 same input -> 0xFFFF then 0x0000.
REQ-035 Change mode_cfg 0->2 mid-frame -> remainder of frame stays bypass (dout=din); next frame binary.
REQ-036 Second sop inside a frame, then eop after 10 pixels -> sop_err=1, len_err=1, frame_cnt increments by 1 only; err_clr -> flags 0.
REQ-037 din_vld without sop after reset -> no dout_vld, orphan_err=1; then rst asserted for 1 cycle during a frame -> outputs 0 next cycle, no stale dout_vld.
